// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared 640x480@60 timing, vram geometry and scan-stage types
// Rev 1.0
// ============================================================================
package vga_pkg;

  function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  localparam int H_TOTAL      = axis_total(640, 16, 96, 48);
  localparam int V_TOTAL      = axis_total(480, 10, 2, 33);
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;

  localparam int VRAM_W  = 128;
  localparam int VRAM_H  = 96;
  localparam int COORD_W = 7;
  localparam int ADDR_W  = 14;

  typedef struct packed {
    logic video_on;
    logic hsync_n;
    logic vsync_n;
  } scan_flags_t;

  localparam scan_flags_t SCAN_FLAGS_IDLE = '{video_on: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// vga_axis_counter : one scan axis - position, sync window and scaled coordinate
// Rev 1.0
// ============================================================================
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VIS       = 640,
  parameter int FP        = 16,
  parameter int SYNC      = 96,
  parameter int BP        = 48,
  parameter int SCALE     = 5,
  parameter int COORD_W   = 7,
  parameter int COORD_MAX = 127
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               adv,
  output logic               wrap,
  output logic               visible,
  output logic               sync_n,
  output logic [COORD_W-1:0] coord
);

  localparam int TOTAL = axis_total(VIS, FP, SYNC, BP);
  localparam int POS_W = $clog2(TOTAL);
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0]   VIS_END    = POS_W'(VIS);
  localparam logic [POS_W-1:0]   SYNC_FIRST = POS_W'(VIS + FP);
  localparam logic [POS_W-1:0]   SYNC_LAST  = POS_W'(VIS + FP + SYNC - 1);
  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(SCALE - 1);
  localparam logic [COORD_W-1:0] COORD_LAST = COORD_W'(COORD_MAX);

  logic [POS_W-1:0] pos;
  logic [SUB_W-1:0] sub;

  assign wrap    = adv && (pos == POS_LAST);
  assign visible = (pos < VIS_END);
  assign sync_n  = !((pos >= SYNC_FIRST) && (pos <= SYNC_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= '0;
    end else if (adv) begin
      if (pos == POS_LAST) begin
        pos <= '0;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

  // Scaling by repeated counting: sub steps through SCALE positions per coordinate,
  // and the coordinate saturates so it can never address beyond the frame buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub   <= '0;
      coord <= '0;
    end else if (wrap) begin
      sub   <= '0;
      coord <= '0;
    end else if (adv && visible) begin
      if (sub == SUB_LAST) begin
        sub <= '0;
        if (coord != COORD_LAST) begin
          coord <= coord + 1'b1;
        end
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// vga_scan_ctrl : 640x480@60 VGA timing, 5x-scaled vram addressing, colour gating
// Rev 1.0
// ============================================================================
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int SCALE   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              red_col,
  input  logic              green_col,
  input  logic              blue_col,
  output logic [ADDR_W-1:0] addr,
  output logic              vga_red,
  output logic              vga_green,
  output logic              vga_blue,
  output logic              hsync,
  output logic              vsync
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div;
  logic               pix_en;
  logic               h_wrap;
  logic               h_visible;
  logic               h_sync_n;
  logic [COORD_W-1:0] h_coord;
  logic               v_wrap_unused;
  logic               v_visible;
  logic               v_sync_n;
  logic [COORD_W-1:0] v_coord;
  scan_flags_t        next_flags;
  scan_flags_t        s1_flags;

  assign pix_en = (div == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (pix_en) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  vga_axis_counter #(
    .VIS      (H_VIS),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SCALE    (SCALE),
    .COORD_W  (COORD_W),
    .COORD_MAX(VRAM_W - 1)
  ) u_h_axis (
    .clk    (clk),
    .reset  (reset),
    .adv    (pix_en),
    .wrap   (h_wrap),
    .visible(h_visible),
    .sync_n (h_sync_n),
    .coord  (h_coord)
  );

  // The vertical axis steps once per completed line, so a line wrap on the last
  // line clears both axes on the same pixel enable.
  vga_axis_counter #(
    .VIS      (V_VIS),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SCALE    (SCALE),
    .COORD_W  (COORD_W),
    .COORD_MAX(VRAM_H - 1)
  ) u_v_axis (
    .clk    (clk),
    .reset  (reset),
    .adv    (h_wrap),
    .wrap   (v_wrap_unused),
    .visible(v_visible),
    .sync_n (v_sync_n),
    .coord  (v_coord)
  );

  assign next_flags = '{video_on: h_visible & v_visible, hsync_n: h_sync_n, vsync_n: v_sync_n};

  // Stage 1: address to vram plus the matching flags; addr freezes during blanking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      s1_flags <= SCAN_FLAGS_IDLE;
    end else begin
      s1_flags <= next_flags;
      if (next_flags.video_on) begin
        addr <= {v_coord, h_coord};
      end
    end
  end

  // Stage 2: vram data arrives here, gated by the flags that travelled with its address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_red   <= 1'b0;
      vga_green <= 1'b0;
      vga_blue  <= 1'b0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else begin
      vga_red   <= red_col   & s1_flags.video_on;
      vga_green <= green_col & s1_flags.video_on;
      vga_blue  <= blue_col  & s1_flags.video_on;
      hsync     <= s1_flags.hsync_n;
      vsync     <= s1_flags.vsync_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_vga_scan_ctrl : directed checks of sync timing, scaled addressing and gating
// Rev 1.0
// ============================================================================
module tb_vga_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_v;
  logic        col_mode;
  logic [2:0]  rgb;
  logic [13:0] addr, addr_v;
  logic        vga_red, vga_green, vga_blue, hsync, vsync;
  logic        red_v, green_v, blue_v, hsync_v, vsync_v;
  int          total = 0;
  int          bad   = 0;
  int          cyc;
  int          cyc_v;

  always #5 clk = ~clk;

  vga_scan_ctrl dut (
    .clk      (clk),
    .reset    (rst),
    .red_col  (rgb[0]),
    .green_col(rgb[1]),
    .blue_col (rgb[2]),
    .addr     (addr),
    .vga_red  (vga_red),
    .vga_green(vga_green),
    .vga_blue (vga_blue),
    .hsync    (hsync),
    .vsync    (vsync)
  );

  // Short-frame instance: 17 lines per frame keeps vertical corners within reach.
  vga_scan_ctrl #(.V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_v (
    .clk      (clk),
    .reset    (rst_v),
    .red_col  (1'b1),
    .green_col(1'b1),
    .blue_col (1'b1),
    .addr     (addr_v),
    .vga_red  (red_v),
    .vga_green(green_v),
    .vga_blue (blue_v),
    .hsync    (hsync_v),
    .vsync    (vsync_v)
  );

  // vram stand-in with one clock of read latency
  always @(posedge clk) rgb <= col_mode ? 3'b111 : addr[2:0];

  always @(posedge clk or posedge rst)   if (rst)   cyc   <= 0; else cyc   <= cyc + 1;
  always @(posedge clk or posedge rst_v) if (rst_v) cyc_v <= 0; else cyc_v <= cyc_v + 1;

  typedef struct {
    int          cyc;
    logic [13:0] addr;
    logic        hsync;
    logic [2:0]  rgb;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_until(input bit use_v, input int n);
    int guard = 0;
    while (((use_v ? cyc_v : cyc) < n) && (guard < 100000)) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("reach_cycle_%0d", n), use_v ? cyc_v : cyc, n);
  endtask

  initial begin
    int falls, first_fall, second_fall, lows, vlows, red_hi, all_hi, red_v_hi;
    logic prev;

    vecs[0]  = '{1,     14'd0,   1'b1, 3'd0};
    vecs[1]  = '{20,    14'd0,   1'b1, 3'd0};
    vecs[2]  = '{21,    14'd1,   1'b1, 3'd0};
    vecs[3]  = '{28,    14'd1,   1'b1, 3'd1};
    vecs[4]  = '{144,   14'd7,   1'b1, 3'd7};
    vecs[5]  = '{164,   14'd8,   1'b1, 3'd0};
    vecs[6]  = '{2560,  14'd127, 1'b1, 3'd7};
    vecs[7]  = '{2564,  14'd127, 1'b1, 3'd0};
    vecs[8]  = '{2625,  14'd127, 1'b1, 3'd0};
    vecs[9]  = '{2626,  14'd127, 1'b0, 3'd0};
    vecs[10] = '{3006,  14'd127, 1'b0, 3'd0};
    vecs[11] = '{3010,  14'd127, 1'b1, 3'd0};
    vecs[12] = '{3200,  14'd127, 1'b1, 3'd0};
    vecs[13] = '{3201,  14'd0,   1'b1, 3'd0};
    vecs[14] = '{3232,  14'd1,   1'b1, 3'd1};
    vecs[15] = '{16000, 14'd127, 1'b1, 3'd0};
    vecs[16] = '{16001, 14'd128, 1'b1, 3'd0};
    vecs[17] = '{16024, 14'd129, 1'b1, 3'd1};

    col_mode = 1'b0;
    rst      = 1'b1;
    rst_v    = 1'b1;
    #95;
    check("rst_addr",  addr, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb",   {vga_blue, vga_green, vga_red}, 0);
    check("rst_v_addr",  addr_v, 0);
    check("rst_v_hsync", hsync_v, 1);
    check("rst_v_vsync", vsync_v, 1);
    check("rst_v_rgb",   {blue_v, green_v, red_v}, 0);
    #5;
    rst   = 1'b0;
    rst_v = 1'b0;

    for (int i = 0; i < 18; i++) begin
      wait_until(1'b0, vecs[i].cyc);
      check($sformatf("vec%0d_addr", i),  addr,  vecs[i].addr);
      check($sformatf("vec%0d_hsync", i), hsync, vecs[i].hsync);
      check($sformatf("vec%0d_rgb", i),   {vga_blue, vga_green, vga_red}, vecs[i].rgb);
    end

    // Two full lines with all colour inputs high.
    col_mode = 1'b1;
    wait_until(1'b0, 16033);
    falls = 0; first_fall = 0; second_fall = 0; lows = 0; vlows = 0;
    red_hi = 0; all_hi = 0; red_v_hi = 0;
    prev = hsync;
    for (int i = 0; i < 6400; i++) begin
      if (prev && !hsync) begin
        falls++;
        if (falls == 1) first_fall = cyc; else second_fall = cyc;
      end
      prev = hsync;
      if (!hsync) lows++;
      if (!vsync) vlows++;
      if (vga_red) red_hi++;
      if (vga_red && vga_green && vga_blue) all_hi++;
      if (red_v) red_v_hi++;
      @(negedge clk);
    end
    check("hsync_falls",       falls, 2);
    check("hsync_first_fall",  first_fall, 18626);
    check("line_period",       second_fall - first_fall, 3200);
    check("hsync_low_clks",    lows, 768);
    check("vsync_low_visible", vlows, 0);
    check("red_high_clks",     red_hi, 5120);
    check("rgb_high_clks",     all_hi, 5120);
    check("v_red_high_clks",   red_v_hi, 5120);

    // Mid-frame reset: line 7, hcnt 300.
    wait_until(1'b0, 23601);
    check("pre_rst_addr", addr, 188);
    check("pre_rst_red",  vga_red, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_addr",  addr, 0);
    check("async_rst_rgb",   {vga_blue, vga_green, vga_red}, 0);
    check("async_rst_hsync", hsync, 1);
    check("async_rst_vsync", vsync, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_until(1'b0, 1);
    check("restart_addr0", addr, 0);
    wait_until(1'b0, 21);
    check("restart_addr1", addr, 1);
    wait_until(1'b0, 2625);
    check("restart_hsync_hi", hsync, 1);
    wait_until(1'b0, 2626);
    check("restart_hsync_lo", hsync, 0);
    wait_until(1'b0, 3201);
    check("restart_line1_addr", addr, 0);
    check("restart_vsync", vsync, 1);

    // Vertical blanking and sync on the short frame.
    wait_until(1'b1, 36000);
    falls = 0; first_fall = 0; vlows = 0; red_v_hi = 0;
    prev = vsync_v;
    for (int i = 0; i < 11000; i++) begin
      if (prev && !vsync_v) begin
        falls++;
        if (falls == 1) first_fall = cyc_v;
      end
      prev = vsync_v;
      if (!vsync_v) vlows++;
      if (red_v || green_v || blue_v) red_v_hi++;
      @(negedge clk);
    end
    check("vsync_falls",      falls, 1);
    check("vsync_first_fall", first_fall, 38402);
    check("vsync_low_clks",   vlows, 6400);
    check("vblank_rgb_clks",  red_v_hi, 0);

    // Line wrap and frame wrap on the same pixel.
    wait_until(1'b1, 54400);
    check("frame_end_addr", addr_v, 255);
    wait_until(1'b1, 54401);
    check("frame_wrap_addr", addr_v, 0);
    check("frame_wrap_red",  red_v, 0);
    wait_until(1'b1, 54402);
    check("new_frame_red",   red_v, 1);
    check("new_frame_vsync", vsync_v, 1);
    check("new_frame_hsync", hsync_v, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
